cushion_fifo: RTL and testbench
===============================

# cushion_fifo

Parametrised, multi-entry successor to the single-register execute/memory-read cushion stage. It buffers up to DEPTH execute results in order between the execute unit and the memory-read stage, decoupling them with a valid/ready handshake. It supports pipeline flush and MEM_WAIT back-pressure. It also provides newest-first register and CSR forwarding lookups across every occupied entry, including a busy indication for pending loads.

## Interface
Parameters:
- DEPTH, 2, number of entries; power of two, 1..16
- XLEN, 32, data/address width
- FWD_EN, 1, 1 = forwarding ports active; 0 = hit/busy outputs tied to 0

Ports:
- CLK  in  1  clock; all state changes on its rising edge
- RST  in  1  reset; asynchronous, active-low; clears all state
- FLUSH  in  1  discard all entries and this cycle's push
- MEM_WAIT  in  1  downstream stall; no pop while high
- EXEC_VALID  in  1  execute result present
- EXEC_READY  out  1  entry can be accepted this cycle
- EXEC_REG_W_EN / _RD / _DATA  in  1/5/XLEN  register write
- EXEC_CSR_W_EN / _ADDR / _DATA  in  1/12/XLEN  CSR write
- EXEC_MEM_R_EN / _RD / _ADDR / _STRB / _SIGNED  in  1/5/XLEN/4/1  load
- EXEC_MEM_W_EN / _ADDR / _STRB / _DATA  in  1/XLEN/4/XLEN  store
- EXEC_JMP_DO / _PC, EXEC_EXC_EN / _CODE  in  1/XLEN, 1/4  jump, exception
- CUSHION_VALID  out  1  head entry valid
- CUSHION_* (same fields as EXEC_*)  out  (same widths)  head entry fields
- FWD_REG_ADDR  in  5  register to look up
- FWD_REG_HIT / FWD_REG_BUSY / FWD_REG_DATA  out  1/1/XLEN  register lookup result
- FWD_CSR_ADDR  in  12  CSR to look up
- FWD_CSR_HIT / FWD_CSR_DATA  out  1/XLEN  CSR lookup result

## Operation
- Circular buffer with write pointer, read pointer and count; log2(DEPTH)+1-bit count, pointers wrap modulo DEPTH.
- pop = CUSHION_VALID && !MEM_WAIT && !FLUSH.
- push = EXEC_VALID && EXEC_READY && !FLUSH.
- EXEC_READY = (count < DEPTH) || pop. When full, a simultaneous push and pop is accepted and count stays at DEPTH.
- Simultaneous push and pop with any count: count unchanged, both pointers advance.
- FLUSH: next cycle count = 0, both pointers = 0; the concurrent push and pop are both suppressed.
- CUSHION_VALID = count != 0. CUSHION_* is driven combinationally from the head entry. When empty, all CUSHION_* outputs are 0 (the EN fields are gated by valid).
- Register forward: scan occupied entries newest to oldest; the first entry whose REG_W_EN or MEM_R_EN targets FWD_REG_ADDR wins.
  - REG_W_EN match: HIT=1, DATA=entry data.
  - MEM_R_EN match: HIT=1, BUSY=1, DATA=0. The requester must stall.
  - FWD_REG_ADDR = 0 never hits.
- CSR forward: same scan on CSR_W_EN / CSR_W_ADDR; no busy case.
- An entry with JMP_DO or EXC_EN is stored and popped like any other entry. Flush generation belongs to downstream stages.

## Timing
- Reset (RST low, async): count, pointers, CUSHION_VALID, EXEC_READY-internal state = 0; every CUSHION_* and FWD_* output = 0. After reset, EXEC_READY = 1.
- Latency: an entry pushed at edge N is visible on CUSHION_* after edge N; minimum latency is 1 cycle, with no bypass.
- Forward outputs are combinational from stored entries and FWD_*_ADDR; the entry being pushed this cycle is not included.
- RST asserted mid-operation: all contents are lost immediately, with no partial pop.
- DEPTH=1: behaves as a single register with ready = empty || pop.

## Structure
- Shared package core_pkg: the cushion entry packed struct (all fields above), plus constants for REG_ADDR_W=5, CSR_ADDR_W=12, STRB_W=4, EXC_CODE_W=4.
- Entry storage is an array of that struct; valid is derived from count, not stored per entry.
- One sub-module, cushion_fwd_match: a priority scan over the entries (rotated newest-first via the write pointer) that returns hit, busy and data. It is instantiated twice, once for registers and once for CSRs.

## Test plan
- DEPTH=4, MEM_WAIT=1, push 5 reg writes (x1..x5 = 0x11..0x55) -> 4 accepted, EXEC_READY=0 on the 5th. Release MEM_WAIT -> pops 0x11,0x22,0x33,0x44 in order, then the 5th is pushed.
- Full buffer, MEM_WAIT=0, continuous push -> EXEC_READY stays 1, count stays 4, throughput 1/cycle.
- Entries x3=0x100 (older) and x3=0x200 (newer), FWD_REG_ADDR=3 -> HIT=1, DATA=0x200. Add a newer load to x3 -> BUSY=1. FWD_REG_ADDR=0 -> HIT=0.
- CSR 0x300 written with 0xA, FWD_CSR_ADDR=0x300 -> HIT=1, DATA=0xA. After pop -> HIT=0.
- 3 entries queued, FLUSH with concurrent push -> next cycle CUSHION_VALID=0, count 0, pushed entry discarded.
- RST low mid-stream with MEM_WAIT=0 -> outputs go to 0 without waiting for a clock. After release, an empty buffer accepts a push and the entry appears 1 cycle later.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the execute/memory-read cushion buffer:
//   - field width constants for register, CSR, strobe and exception codes
//   - cushion_entry_t, the packed record buffered for every execute result
//   - wrap_inc, a modulo pointer increment used for circular buffers
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int CORE_XLEN  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CSR_ADDR_W = 12;
    localparam int STRB_W     = 4;
    localparam int EXC_CODE_W = 4;

    typedef struct packed {
        logic                  reg_w_en;
        logic [REG_ADDR_W-1:0] reg_w_rd;
        logic [CORE_XLEN-1:0]  reg_w_data;
        logic                  csr_w_en;
        logic [CSR_ADDR_W-1:0] csr_w_addr;
        logic [CORE_XLEN-1:0]  csr_w_data;
        logic                  mem_r_en;
        logic [REG_ADDR_W-1:0] mem_r_rd;
        logic [CORE_XLEN-1:0]  mem_r_addr;
        logic [STRB_W-1:0]     mem_r_strb;
        logic                  mem_r_signed;
        logic                  mem_w_en;
        logic [CORE_XLEN-1:0]  mem_w_addr;
        logic [STRB_W-1:0]     mem_w_strb;
        logic [CORE_XLEN-1:0]  mem_w_data;
        logic                  jmp_do;
        logic [CORE_XLEN-1:0]  jmp_pc;
        logic                  exc_en;
        logic [EXC_CODE_W-1:0] exc_code;
    } cushion_entry_t;

    // Next pointer value in a circular buffer of 'depth' slots.
    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr + 32'sd1) % depth;
    endfunction

endpackage

// File: rtl/cushion_fwd_match.sv
// ---------------------------------------------------------------------------
// cushion_fwd_match
// Newest-first priority scan over the occupied cushion entries. Slot order is
// rotated with the write pointer so the most recently pushed entry is checked
// first. A "busy" match (pending load) reports hit+busy with zero data; a
// write match reports hit with the stored data.
// Ports:
//   count       number of occupied entries
//   wr_ptr      write pointer (slot after the newest entry)
//   lookup_addr address being looked up
//   wr_en/wr_addr/wr_data     per-slot write candidates
//   busy_en/busy_addr         per-slot pending-result candidates
//   hit/busy/data             lookup result
// ---------------------------------------------------------------------------
module cushion_fwd_match #(
    parameter int DEPTH        = 2,
    parameter int PTR_W        = 1,
    parameter int CNT_W        = 2,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int ZERO_IS_NULL = 1
) (
    input  logic [CNT_W-1:0]              count,
    input  logic [PTR_W-1:0]              wr_ptr,
    input  logic [ADDR_W-1:0]             lookup_addr,
    input  logic [DEPTH-1:0]              wr_en,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  wr_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  wr_data,
    input  logic [DEPTH-1:0]              busy_en,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  busy_addr,
    output logic                          hit,
    output logic                          busy,
    output logic [DATA_W-1:0]             data
);

    logic             lookup_ok_s;
    logic             found_s;
    logic [PTR_W-1:0] idx_s;

    // Address zero is a hard-wired constant on the register side and never matches.
    assign lookup_ok_s = !((ZERO_IS_NULL != 0) && (lookup_addr == '0));

    // Priority scan from newest to oldest; the first matching entry wins.
    always_comb begin
        hit     = 1'b0;
        busy    = 1'b0;
        data    = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = PTR_W'((int'(wr_ptr) + DEPTH - 1 - i) % DEPTH);
            if (!found_s && lookup_ok_s && (CNT_W'(i) < count)) begin
                if (busy_en[idx_s] && (busy_addr[idx_s] == lookup_addr)) begin
                    found_s = 1'b1;
                    hit     = 1'b1;
                    busy    = 1'b1;
                    data    = '0;
                end else if (wr_en[idx_s] && (wr_addr[idx_s] == lookup_addr)) begin
                    found_s = 1'b1;
                    hit     = 1'b1;
                    busy    = 1'b0;
                    data    = wr_data[idx_s];
                end else begin
                    found_s = found_s;
                end
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/cushion_fifo.sv
// ---------------------------------------------------------------------------
// cushion_fifo
// DEPTH-entry in-order buffer between the execute unit and the memory-read
// stage. Valid/ready handshake on the execute side, MEM_WAIT stall and FLUSH
// on the downstream side, plus newest-first register/CSR forwarding lookups
// over every occupied entry.
// Ports:
//   CLK, RST (async, active-low)
//   FLUSH      drop all entries and this cycle's push
//   MEM_WAIT   downstream stall, blocks pop
//   EXEC_*     incoming execute result, EXEC_VALID/EXEC_READY handshake
//   CUSHION_*  head entry (all zero when empty)
//   FWD_REG_*  register forwarding lookup (hit/busy/data)
//   FWD_CSR_*  CSR forwarding lookup (hit/data)
// ---------------------------------------------------------------------------
module cushion_fifo
    import core_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int XLEN   = 32,
    parameter int FWD_EN = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic                  MEM_WAIT,
    input  logic                  EXEC_VALID,
    output logic                  EXEC_READY,
    input  logic                  EXEC_REG_W_EN,
    input  logic [REG_ADDR_W-1:0] EXEC_REG_W_RD,
    input  logic [XLEN-1:0]       EXEC_REG_W_DATA,
    input  logic                  EXEC_CSR_W_EN,
    input  logic [CSR_ADDR_W-1:0] EXEC_CSR_W_ADDR,
    input  logic [XLEN-1:0]       EXEC_CSR_W_DATA,
    input  logic                  EXEC_MEM_R_EN,
    input  logic [REG_ADDR_W-1:0] EXEC_MEM_R_RD,
    input  logic [XLEN-1:0]       EXEC_MEM_R_ADDR,
    input  logic [STRB_W-1:0]     EXEC_MEM_R_STRB,
    input  logic                  EXEC_MEM_R_SIGNED,
    input  logic                  EXEC_MEM_W_EN,
    input  logic [XLEN-1:0]       EXEC_MEM_W_ADDR,
    input  logic [STRB_W-1:0]     EXEC_MEM_W_STRB,
    input  logic [XLEN-1:0]       EXEC_MEM_W_DATA,
    input  logic                  EXEC_JMP_DO,
    input  logic [XLEN-1:0]       EXEC_JMP_PC,
    input  logic                  EXEC_EXC_EN,
    input  logic [EXC_CODE_W-1:0] EXEC_EXC_CODE,
    output logic                  CUSHION_VALID,
    output logic                  CUSHION_REG_W_EN,
    output logic [REG_ADDR_W-1:0] CUSHION_REG_W_RD,
    output logic [XLEN-1:0]       CUSHION_REG_W_DATA,
    output logic                  CUSHION_CSR_W_EN,
    output logic [CSR_ADDR_W-1:0] CUSHION_CSR_W_ADDR,
    output logic [XLEN-1:0]       CUSHION_CSR_W_DATA,
    output logic                  CUSHION_MEM_R_EN,
    output logic [REG_ADDR_W-1:0] CUSHION_MEM_R_RD,
    output logic [XLEN-1:0]       CUSHION_MEM_R_ADDR,
    output logic [STRB_W-1:0]     CUSHION_MEM_R_STRB,
    output logic                  CUSHION_MEM_R_SIGNED,
    output logic                  CUSHION_MEM_W_EN,
    output logic [XLEN-1:0]       CUSHION_MEM_W_ADDR,
    output logic [STRB_W-1:0]     CUSHION_MEM_W_STRB,
    output logic [XLEN-1:0]       CUSHION_MEM_W_DATA,
    output logic                  CUSHION_JMP_DO,
    output logic [XLEN-1:0]       CUSHION_JMP_PC,
    output logic                  CUSHION_EXC_EN,
    output logic [EXC_CODE_W-1:0] CUSHION_EXC_CODE,
    input  logic [REG_ADDR_W-1:0] FWD_REG_ADDR,
    output logic                  FWD_REG_HIT,
    output logic                  FWD_REG_BUSY,
    output logic [XLEN-1:0]       FWD_REG_DATA,
    input  logic [CSR_ADDR_W-1:0] FWD_CSR_ADDR,
    output logic                  FWD_CSR_HIT,
    output logic [XLEN-1:0]       FWD_CSR_DATA
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    cushion_entry_t   entries_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic             valid_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic [PTR_W-1:0] wr_ptr_inc_s;
    logic [PTR_W-1:0] rd_ptr_inc_s;
    cushion_entry_t   exec_entry_s;
    cushion_entry_t   head_s;

    logic [DEPTH-1:0]                           reg_w_en_v_s;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]           reg_w_rd_v_s;
    logic [DEPTH-1:0][CORE_XLEN-1:0]            reg_w_data_v_s;
    logic [DEPTH-1:0]                           mem_r_en_v_s;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]           mem_r_rd_v_s;
    logic [DEPTH-1:0]                           csr_w_en_v_s;
    logic [DEPTH-1:0][CSR_ADDR_W-1:0]           csr_w_addr_v_s;
    logic [DEPTH-1:0][CORE_XLEN-1:0]            csr_w_data_v_s;

    logic                 reg_hit_s;
    logic                 reg_busy_s;
    logic [CORE_XLEN-1:0] reg_data_s;
    logic                 csr_hit_s;
    logic                 csr_busy_s;
    logic [CORE_XLEN-1:0] csr_data_s;

    assign valid_s      = (count_r != '0);
    assign full_s       = (count_r == CNT_W'(DEPTH));
    assign pop_s        = valid_s && !MEM_WAIT && !FLUSH;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign EXEC_READY   = !full_s || pop_s;
    assign push_s       = EXEC_VALID && EXEC_READY && !FLUSH;
    assign wr_ptr_inc_s = PTR_W'(wrap_inc(int'(wr_ptr_r), DEPTH));
    assign rd_ptr_inc_s = PTR_W'(wrap_inc(int'(rd_ptr_r), DEPTH));

    // Pack the incoming execute result into an entry record.
    always_comb begin
        exec_entry_s              = '0;
        exec_entry_s.reg_w_en     = EXEC_REG_W_EN;
        exec_entry_s.reg_w_rd     = EXEC_REG_W_RD;
        exec_entry_s.reg_w_data   = CORE_XLEN'(EXEC_REG_W_DATA);
        exec_entry_s.csr_w_en     = EXEC_CSR_W_EN;
        exec_entry_s.csr_w_addr   = EXEC_CSR_W_ADDR;
        exec_entry_s.csr_w_data   = CORE_XLEN'(EXEC_CSR_W_DATA);
        exec_entry_s.mem_r_en     = EXEC_MEM_R_EN;
        exec_entry_s.mem_r_rd     = EXEC_MEM_R_RD;
        exec_entry_s.mem_r_addr   = CORE_XLEN'(EXEC_MEM_R_ADDR);
        exec_entry_s.mem_r_strb   = EXEC_MEM_R_STRB;
        exec_entry_s.mem_r_signed = EXEC_MEM_R_SIGNED;
        exec_entry_s.mem_w_en     = EXEC_MEM_W_EN;
        exec_entry_s.mem_w_addr   = CORE_XLEN'(EXEC_MEM_W_ADDR);
        exec_entry_s.mem_w_strb   = EXEC_MEM_W_STRB;
        exec_entry_s.mem_w_data   = CORE_XLEN'(EXEC_MEM_W_DATA);
        exec_entry_s.jmp_do       = EXEC_JMP_DO;
        exec_entry_s.jmp_pc       = CORE_XLEN'(EXEC_JMP_PC);
        exec_entry_s.exc_en       = EXEC_EXC_EN;
        exec_entry_s.exc_code     = EXEC_EXC_CODE;
    end

    // Pointer, count and storage update; FLUSH overrides any push or pop.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else if (FLUSH) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                entries_r[wr_ptr_r] <= exec_entry_s;
                wr_ptr_r            <= wr_ptr_inc_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head entry, forced to zero when nothing is stored.
    always_comb begin
        head_s = '0;
        if (valid_s) begin
            head_s = entries_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    assign CUSHION_VALID        = valid_s;
    assign CUSHION_REG_W_EN     = head_s.reg_w_en;
    assign CUSHION_REG_W_RD     = head_s.reg_w_rd;
    assign CUSHION_REG_W_DATA   = XLEN'(head_s.reg_w_data);
    assign CUSHION_CSR_W_EN     = head_s.csr_w_en;
    assign CUSHION_CSR_W_ADDR   = head_s.csr_w_addr;
    assign CUSHION_CSR_W_DATA   = XLEN'(head_s.csr_w_data);
    assign CUSHION_MEM_R_EN     = head_s.mem_r_en;
    assign CUSHION_MEM_R_RD     = head_s.mem_r_rd;
    assign CUSHION_MEM_R_ADDR   = XLEN'(head_s.mem_r_addr);
    assign CUSHION_MEM_R_STRB   = head_s.mem_r_strb;
    assign CUSHION_MEM_R_SIGNED = head_s.mem_r_signed;
    assign CUSHION_MEM_W_EN     = head_s.mem_w_en;
    assign CUSHION_MEM_W_ADDR   = XLEN'(head_s.mem_w_addr);
    assign CUSHION_MEM_W_STRB   = head_s.mem_w_strb;
    assign CUSHION_MEM_W_DATA   = XLEN'(head_s.mem_w_data);
    assign CUSHION_JMP_DO       = head_s.jmp_do;
    assign CUSHION_JMP_PC       = XLEN'(head_s.jmp_pc);
    assign CUSHION_EXC_EN       = head_s.exc_en;
    assign CUSHION_EXC_CODE     = head_s.exc_code;

    // Flatten the slot fields that the forwarding scans look at.
    always_comb begin
        reg_w_en_v_s   = '0;
        reg_w_rd_v_s   = '0;
        reg_w_data_v_s = '0;
        mem_r_en_v_s   = '0;
        mem_r_rd_v_s   = '0;
        csr_w_en_v_s   = '0;
        csr_w_addr_v_s = '0;
        csr_w_data_v_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            reg_w_en_v_s[i]   = entries_r[i].reg_w_en;
            reg_w_rd_v_s[i]   = entries_r[i].reg_w_rd;
            reg_w_data_v_s[i] = entries_r[i].reg_w_data;
            mem_r_en_v_s[i]   = entries_r[i].mem_r_en;
            mem_r_rd_v_s[i]   = entries_r[i].mem_r_rd;
            csr_w_en_v_s[i]   = entries_r[i].csr_w_en;
            csr_w_addr_v_s[i] = entries_r[i].csr_w_addr;
            csr_w_data_v_s[i] = entries_r[i].csr_w_data;
        end
    end

    cushion_fwd_match #(
        .DEPTH        (DEPTH),
        .PTR_W        (PTR_W),
        .CNT_W        (CNT_W),
        .ADDR_W       (REG_ADDR_W),
        .DATA_W       (CORE_XLEN),
        .ZERO_IS_NULL (1)
    ) u_reg_match (
        .count       (count_r),
        .wr_ptr      (wr_ptr_r),
        .lookup_addr (FWD_REG_ADDR),
        .wr_en       (reg_w_en_v_s),
        .wr_addr     (reg_w_rd_v_s),
        .wr_data     (reg_w_data_v_s),
        .busy_en     (mem_r_en_v_s),
        .busy_addr   (mem_r_rd_v_s),
        .hit         (reg_hit_s),
        .busy        (reg_busy_s),
        .data        (reg_data_s)
    );

    // CSRs have no pending-result case, so the busy inputs are tied off.
    cushion_fwd_match #(
        .DEPTH        (DEPTH),
        .PTR_W        (PTR_W),
        .CNT_W        (CNT_W),
        .ADDR_W       (CSR_ADDR_W),
        .DATA_W       (CORE_XLEN),
        .ZERO_IS_NULL (0)
    ) u_csr_match (
        .count       (count_r),
        .wr_ptr      (wr_ptr_r),
        .lookup_addr (FWD_CSR_ADDR),
        .wr_en       (csr_w_en_v_s),
        .wr_addr     (csr_w_addr_v_s),
        .wr_data     (csr_w_data_v_s),
        .busy_en     ({DEPTH{1'b0}}),
        .busy_addr   ({DEPTH{{CSR_ADDR_W{1'b0}}}}),
        .hit         (csr_hit_s),
        .busy        (csr_busy_s),
        .data        (csr_data_s)
    );

    assign FWD_REG_HIT  = (FWD_EN != 0) ? reg_hit_s : 1'b0;
    assign FWD_REG_BUSY = (FWD_EN != 0) ? reg_busy_s : 1'b0;
    assign FWD_REG_DATA = (FWD_EN != 0) ? XLEN'(reg_data_s) : {XLEN{1'b0}};
    assign FWD_CSR_HIT  = (FWD_EN != 0) ? (csr_hit_s && !csr_busy_s) : 1'b0;
    assign FWD_CSR_DATA = (FWD_EN != 0) ? XLEN'(csr_data_s) : {XLEN{1'b0}};

endmodule

// File: tb/tb_cushion_fifo.sv
// ---------------------------------------------------------------------------
// tb_cushion_fifo
// Directed self-checking bench for cushion_fifo (DEPTH=4). Inputs change on
// the falling clock edge; outputs are sampled 1 time unit later, well away
// from the rising edge where state changes.
// ---------------------------------------------------------------------------
module tb_cushion_fifo;

    logic        CLK = 1'b0;
    logic        RST;
    logic        FLUSH;
    logic        MEM_WAIT;
    logic        EXEC_VALID;
    logic        EXEC_READY;
    logic        EXEC_REG_W_EN;
    logic [4:0]  EXEC_REG_W_RD;
    logic [31:0] EXEC_REG_W_DATA;
    logic        EXEC_CSR_W_EN;
    logic [11:0] EXEC_CSR_W_ADDR;
    logic [31:0] EXEC_CSR_W_DATA;
    logic        EXEC_MEM_R_EN;
    logic [4:0]  EXEC_MEM_R_RD;
    logic [31:0] EXEC_MEM_R_ADDR;
    logic [3:0]  EXEC_MEM_R_STRB;
    logic        EXEC_MEM_R_SIGNED;
    logic        EXEC_MEM_W_EN;
    logic [31:0] EXEC_MEM_W_ADDR;
    logic [3:0]  EXEC_MEM_W_STRB;
    logic [31:0] EXEC_MEM_W_DATA;
    logic        EXEC_JMP_DO;
    logic [31:0] EXEC_JMP_PC;
    logic        EXEC_EXC_EN;
    logic [3:0]  EXEC_EXC_CODE;
    logic        CUSHION_VALID;
    logic        CUSHION_REG_W_EN;
    logic [4:0]  CUSHION_REG_W_RD;
    logic [31:0] CUSHION_REG_W_DATA;
    logic        CUSHION_CSR_W_EN;
    logic [11:0] CUSHION_CSR_W_ADDR;
    logic [31:0] CUSHION_CSR_W_DATA;
    logic        CUSHION_MEM_R_EN;
    logic [4:0]  CUSHION_MEM_R_RD;
    logic [31:0] CUSHION_MEM_R_ADDR;
    logic [3:0]  CUSHION_MEM_R_STRB;
    logic        CUSHION_MEM_R_SIGNED;
    logic        CUSHION_MEM_W_EN;
    logic [31:0] CUSHION_MEM_W_ADDR;
    logic [3:0]  CUSHION_MEM_W_STRB;
    logic [31:0] CUSHION_MEM_W_DATA;
    logic        CUSHION_JMP_DO;
    logic [31:0] CUSHION_JMP_PC;
    logic        CUSHION_EXC_EN;
    logic [3:0]  CUSHION_EXC_CODE;
    logic [4:0]  FWD_REG_ADDR;
    logic        FWD_REG_HIT;
    logic        FWD_REG_BUSY;
    logic [31:0] FWD_REG_DATA;
    logic [11:0] FWD_CSR_ADDR;
    logic        FWD_CSR_HIT;
    logic [31:0] FWD_CSR_DATA;

    int total_cnt = 0;
    int bad_cnt   = 0;

    cushion_fifo #(.DEPTH(4), .XLEN(32), .FWD_EN(1)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
        .EXEC_VALID(EXEC_VALID), .EXEC_READY(EXEC_READY),
        .EXEC_REG_W_EN(EXEC_REG_W_EN), .EXEC_REG_W_RD(EXEC_REG_W_RD), .EXEC_REG_W_DATA(EXEC_REG_W_DATA),
        .EXEC_CSR_W_EN(EXEC_CSR_W_EN), .EXEC_CSR_W_ADDR(EXEC_CSR_W_ADDR), .EXEC_CSR_W_DATA(EXEC_CSR_W_DATA),
        .EXEC_MEM_R_EN(EXEC_MEM_R_EN), .EXEC_MEM_R_RD(EXEC_MEM_R_RD), .EXEC_MEM_R_ADDR(EXEC_MEM_R_ADDR),
        .EXEC_MEM_R_STRB(EXEC_MEM_R_STRB), .EXEC_MEM_R_SIGNED(EXEC_MEM_R_SIGNED),
        .EXEC_MEM_W_EN(EXEC_MEM_W_EN), .EXEC_MEM_W_ADDR(EXEC_MEM_W_ADDR), .EXEC_MEM_W_STRB(EXEC_MEM_W_STRB),
        .EXEC_MEM_W_DATA(EXEC_MEM_W_DATA), .EXEC_JMP_DO(EXEC_JMP_DO), .EXEC_JMP_PC(EXEC_JMP_PC),
        .EXEC_EXC_EN(EXEC_EXC_EN), .EXEC_EXC_CODE(EXEC_EXC_CODE),
        .CUSHION_VALID(CUSHION_VALID),
        .CUSHION_REG_W_EN(CUSHION_REG_W_EN), .CUSHION_REG_W_RD(CUSHION_REG_W_RD), .CUSHION_REG_W_DATA(CUSHION_REG_W_DATA),
        .CUSHION_CSR_W_EN(CUSHION_CSR_W_EN), .CUSHION_CSR_W_ADDR(CUSHION_CSR_W_ADDR), .CUSHION_CSR_W_DATA(CUSHION_CSR_W_DATA),
        .CUSHION_MEM_R_EN(CUSHION_MEM_R_EN), .CUSHION_MEM_R_RD(CUSHION_MEM_R_RD), .CUSHION_MEM_R_ADDR(CUSHION_MEM_R_ADDR),
        .CUSHION_MEM_R_STRB(CUSHION_MEM_R_STRB), .CUSHION_MEM_R_SIGNED(CUSHION_MEM_R_SIGNED),
        .CUSHION_MEM_W_EN(CUSHION_MEM_W_EN), .CUSHION_MEM_W_ADDR(CUSHION_MEM_W_ADDR), .CUSHION_MEM_W_STRB(CUSHION_MEM_W_STRB),
        .CUSHION_MEM_W_DATA(CUSHION_MEM_W_DATA), .CUSHION_JMP_DO(CUSHION_JMP_DO), .CUSHION_JMP_PC(CUSHION_JMP_PC),
        .CUSHION_EXC_EN(CUSHION_EXC_EN), .CUSHION_EXC_CODE(CUSHION_EXC_CODE),
        .FWD_REG_ADDR(FWD_REG_ADDR), .FWD_REG_HIT(FWD_REG_HIT), .FWD_REG_BUSY(FWD_REG_BUSY), .FWD_REG_DATA(FWD_REG_DATA),
        .FWD_CSR_ADDR(FWD_CSR_ADDR), .FWD_CSR_HIT(FWD_CSR_HIT), .FWD_CSR_DATA(FWD_CSR_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_exec();
        EXEC_VALID = 1'b0;
        EXEC_REG_W_EN = 1'b0; EXEC_REG_W_RD = 5'd0; EXEC_REG_W_DATA = 32'd0;
        EXEC_CSR_W_EN = 1'b0; EXEC_CSR_W_ADDR = 12'd0; EXEC_CSR_W_DATA = 32'd0;
        EXEC_MEM_R_EN = 1'b0; EXEC_MEM_R_RD = 5'd0; EXEC_MEM_R_ADDR = 32'd0;
        EXEC_MEM_R_STRB = 4'd0; EXEC_MEM_R_SIGNED = 1'b0;
        EXEC_MEM_W_EN = 1'b0; EXEC_MEM_W_ADDR = 32'd0; EXEC_MEM_W_STRB = 4'd0; EXEC_MEM_W_DATA = 32'd0;
        EXEC_JMP_DO = 1'b0; EXEC_JMP_PC = 32'd0; EXEC_EXC_EN = 1'b0; EXEC_EXC_CODE = 4'd0;
    endtask

    task automatic drive_reg(input logic [4:0] rd, input logic [31:0] d);
        clear_exec();
        EXEC_VALID      = 1'b1;
        EXEC_REG_W_EN   = 1'b1;
        EXEC_REG_W_RD   = rd;
        EXEC_REG_W_DATA = d;
    endtask

    initial begin
        RST = 1'b0; FLUSH = 1'b0; MEM_WAIT = 1'b0;
        clear_exec();
        FWD_REG_ADDR = 5'd0; FWD_CSR_ADDR = 12'd0;

        // Reset state
        #3;
        check_eq("rst_valid", 64'(CUSHION_VALID), 64'd0);
        check_eq("rst_ready", 64'(EXEC_READY), 64'd1);
        check_eq("rst_head_data", 64'(CUSHION_REG_W_DATA), 64'd0);
        check_eq("rst_fwd_hit", 64'(FWD_REG_HIT), 64'd0);
        @(negedge CLK); RST = 1'b1;

        // Fill under MEM_WAIT: four accepted, fifth refused
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK); MEM_WAIT = 1'b1; drive_reg(5'(k), 32'(k * 17));
            #1; check_eq("fill_ready", 64'(EXEC_READY), 64'(k <= 4));
        end
        // Release: x5 enters while 0x11 leaves, then in-order drain
        @(negedge CLK); MEM_WAIT = 1'b0;
        #1; check_eq("drain_ready_full_pop", 64'(EXEC_READY), 64'd1);
        check_eq("drain_head", 64'(CUSHION_REG_W_DATA), 64'h11);
        for (int k = 2; k <= 5; k++) begin
            @(negedge CLK); clear_exec();
            #1; check_eq("drain_head", 64'(CUSHION_REG_W_DATA), 64'(k * 17));
            check_eq("drain_rd", 64'(CUSHION_REG_W_RD), 64'(k));
        end
        @(negedge CLK);
        #1; check_eq("drain_empty", 64'(CUSHION_VALID), 64'd0);

        // Full buffer streaming at one entry per cycle
        for (int j = 0; j < 4; j++) begin
            @(negedge CLK); MEM_WAIT = 1'b1; drive_reg(5'd1, 32'(32'hA0 + j));
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge CLK); MEM_WAIT = 1'b0; drive_reg(5'd2, 32'(32'hB0 + j));
            #1; check_eq("stream_ready", 64'(EXEC_READY), 64'd1);
            check_eq("stream_head", 64'(CUSHION_REG_W_DATA), 64'(32'hA0 + j));
        end
        @(negedge CLK); MEM_WAIT = 1'b1; drive_reg(5'd2, 32'hC0);
        #1; check_eq("stream_still_full", 64'(EXEC_READY), 64'd0);
        check_eq("stream_head_b0", 64'(CUSHION_REG_W_DATA), 64'hB0);
        @(negedge CLK); FLUSH = 1'b1; clear_exec();
        @(negedge CLK); FLUSH = 1'b0;
        #1; check_eq("flush_valid", 64'(CUSHION_VALID), 64'd0);
        check_eq("empty_gated_en", 64'(CUSHION_REG_W_EN), 64'd0);
        check_eq("empty_gated_data", 64'(CUSHION_REG_W_DATA), 64'd0);

        // Register forwarding, newest first, busy on pending load
        @(negedge CLK); drive_reg(5'd3, 32'h100); FWD_REG_ADDR = 5'd3;
        #1; check_eq("fwd_push_not_seen", 64'(FWD_REG_HIT), 64'd0);
        @(negedge CLK); drive_reg(5'd3, 32'h200);
        #1; check_eq("fwd_one_data", 64'(FWD_REG_DATA), 64'h100);
        @(negedge CLK); clear_exec(); EXEC_VALID = 1'b1; EXEC_MEM_R_EN = 1'b1;
        EXEC_MEM_R_RD = 5'd3; EXEC_MEM_R_ADDR = 32'h8000;
        #1; check_eq("fwd_newest_hit", 64'(FWD_REG_HIT), 64'd1);
        check_eq("fwd_newest_data", 64'(FWD_REG_DATA), 64'h200);
        check_eq("fwd_newest_busy", 64'(FWD_REG_BUSY), 64'd0);
        @(negedge CLK); drive_reg(5'd0, 32'h77);
        #1; check_eq("fwd_load_hit", 64'(FWD_REG_HIT), 64'd1);
        check_eq("fwd_load_busy", 64'(FWD_REG_BUSY), 64'd1);
        check_eq("fwd_load_data", 64'(FWD_REG_DATA), 64'd0);
        @(negedge CLK); clear_exec(); FWD_REG_ADDR = 5'd0;
        #1; check_eq("fwd_x0_hit", 64'(FWD_REG_HIT), 64'd0);
        check_eq("fwd_x0_busy", 64'(FWD_REG_BUSY), 64'd0);
        check_eq("fwd_head", 64'(CUSHION_REG_W_DATA), 64'h100);
        FWD_REG_ADDR = 5'd5;
        #1; check_eq("fwd_miss", 64'(FWD_REG_HIT), 64'd0);
        @(negedge CLK); FLUSH = 1'b1;
        @(negedge CLK); FLUSH = 1'b0;

        // CSR forwarding and its disappearance after the pop
        @(negedge CLK); clear_exec(); EXEC_VALID = 1'b1; EXEC_CSR_W_EN = 1'b1;
        EXEC_CSR_W_ADDR = 12'h300; EXEC_CSR_W_DATA = 32'hA;
        @(negedge CLK); clear_exec(); FWD_CSR_ADDR = 12'h300;
        #1; check_eq("csr_hit", 64'(FWD_CSR_HIT), 64'd1);
        check_eq("csr_data", 64'(FWD_CSR_DATA), 64'hA);
        check_eq("csr_head_addr", 64'(CUSHION_CSR_W_ADDR), 64'h300);
        FWD_CSR_ADDR = 12'h301;
        #1; check_eq("csr_other_miss", 64'(FWD_CSR_HIT), 64'd0);
        FWD_CSR_ADDR = 12'h300;
        @(negedge CLK); MEM_WAIT = 1'b0;
        @(negedge CLK);
        #1; check_eq("csr_after_pop", 64'(FWD_CSR_HIT), 64'd0);
        check_eq("csr_after_pop_valid", 64'(CUSHION_VALID), 64'd0);

        // Flush with three entries and a concurrent push
        for (int j = 0; j < 3; j++) begin
            @(negedge CLK); MEM_WAIT = 1'b1; drive_reg(5'd7, 32'(j + 1));
        end
        @(negedge CLK); FLUSH = 1'b1; drive_reg(5'd9, 32'h99);
        #1; check_eq("preflush_valid", 64'(CUSHION_VALID), 64'd1);
        @(negedge CLK); FLUSH = 1'b0; clear_exec(); FWD_REG_ADDR = 5'd9;
        #1; check_eq("postflush_valid", 64'(CUSHION_VALID), 64'd0);
        check_eq("postflush_no_push", 64'(FWD_REG_HIT), 64'd0);
        for (int j = 0; j < 5; j++) begin
            @(negedge CLK); drive_reg(5'd10, 32'(32'h1000 + j));
            #1; check_eq("postflush_fill_ready", 64'(EXEC_READY), 64'(j < 4));
        end

        // Asynchronous reset in the middle of a clock period
        @(negedge CLK); clear_exec(); MEM_WAIT = 1'b0; FWD_REG_ADDR = 5'd10;
        #1; check_eq("prerst_fwd", 64'(FWD_REG_DATA), 64'h1003);
        check_eq("prerst_head", 64'(CUSHION_REG_W_DATA), 64'h1000);
        #1; RST = 1'b0;
        #1; check_eq("arst_valid", 64'(CUSHION_VALID), 64'd0);
        check_eq("arst_head", 64'(CUSHION_REG_W_DATA), 64'd0);
        check_eq("arst_fwd", 64'(FWD_REG_HIT), 64'd0);
        check_eq("arst_ready", 64'(EXEC_READY), 64'd1);
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); drive_reg(5'd12, 32'hCAFE);
        EXEC_JMP_DO = 1'b1; EXEC_JMP_PC = 32'h400; EXEC_EXC_EN = 1'b1; EXEC_EXC_CODE = 4'd6;
        EXEC_MEM_W_EN = 1'b1; EXEC_MEM_W_ADDR = 32'h2000; EXEC_MEM_W_STRB = 4'hF; EXEC_MEM_W_DATA = 32'hBEEF;
        #1; check_eq("post_rst_ready", 64'(EXEC_READY), 64'd1);
        check_eq("no_bypass", 64'(CUSHION_VALID), 64'd0);
        @(negedge CLK); clear_exec();
        #1; check_eq("lat1_valid", 64'(CUSHION_VALID), 64'd1);
        check_eq("lat1_data", 64'(CUSHION_REG_W_DATA), 64'hCAFE);
        check_eq("lat1_jmp", 64'({CUSHION_JMP_DO, CUSHION_JMP_PC}), 64'h1_0000_0400);
        check_eq("lat1_exc", 64'({CUSHION_EXC_EN, CUSHION_EXC_CODE}), 64'h16);
        check_eq("lat1_store", 64'({CUSHION_MEM_W_EN, CUSHION_MEM_W_STRB, CUSHION_MEM_W_DATA}), 64'h1F_0000_BEEF);
        check_eq("lat1_store_addr", 64'(CUSHION_MEM_W_ADDR), 64'h2000);
        @(negedge CLK);
        #1; check_eq("final_pop", 64'(CUSHION_VALID), 64'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
